// File: rtl/dot_product_seq_ctrl_if.sv
// Handshake and datapath bus for the dot-product sequencing controller.
// The slave modport is the controller side; master is the job/datapath side.
interface dot_product_seq_ctrl_if #(
  parameter int unsigned ACC_W = 23,
  parameter int unsigned LEN_W = 5
);
  localparam int unsigned VEC_W = 64;
  localparam int unsigned DP_W  = 19;

  logic             job_valid;
  logic             job_ready;
  logic [LEN_W-1:0] job_len;

  logic             chunk_valid;
  logic             chunk_ready;
  logic [VEC_W-1:0] chunk_a;
  logic [VEC_W-1:0] chunk_b;

  logic             dp_start;
  logic [VEC_W-1:0] dp_vec_a;
  logic [VEC_W-1:0] dp_vec_b;
  logic             dp_res_valid;
  logic [DP_W-1:0]  dp_res;

  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic [LEN_W-1:0] res_chunks;

  logic             busy;
  logic             err_spurious;

  modport slave (
    input  job_valid, job_len, chunk_valid, chunk_a, chunk_b,
           dp_res_valid, dp_res, res_ready,
    output job_ready, chunk_ready, dp_start, dp_vec_a, dp_vec_b,
           res_valid, res_data, res_chunks, busy, err_spurious
  );

  modport master (
    output job_valid, job_len, chunk_valid, chunk_a, chunk_b,
           dp_res_valid, dp_res, res_ready,
    input  job_ready, chunk_ready, dp_start, dp_vec_a, dp_vec_b,
           res_valid, res_data, res_chunks, busy, err_spurious
  );
endinterface

// File: rtl/dot_product_seq_ctrl.sv
// Sequences 8-element chunks of a job into a pipelined tree-add datapath with
// a bounded number of operations in flight, and accumulates the returned sums.
module dot_product_seq_ctrl #(
  parameter int unsigned MAX_CHUNKS      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ACC_W           = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  dot_product_seq_ctrl_if.slave bus
);
  localparam int unsigned LEN_W = 5;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHUNKS);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] len, len_n;
  logic [LEN_W-1:0] issued, issued_n;
  logic [LEN_W-1:0] returned, returned_n;
  logic [OUT_W-1:0] outstanding, outstanding_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic             job_hs, chunk_hs, res_take, res_drop, res_done;

  // Next-state values; outputs below are registered from these so that each
  // output equals its rule applied to the current state registers.
  always_comb begin
    job_hs   = (state == IDLE) && bus.job_valid && bus.job_ready;
    chunk_hs = bus.chunk_valid && bus.chunk_ready;
    res_take = bus.dp_res_valid && ((state == ISSUE) || (state == DRAIN)) &&
               (outstanding != '0);
    res_drop = bus.dp_res_valid && !res_take;
    res_done = bus.res_valid && bus.res_ready;

    state_n       = state;
    len_n         = len;
    issued_n      = issued + LEN_W'(chunk_hs);
    returned_n    = returned + LEN_W'(res_take);
    outstanding_n = outstanding + OUT_W'(chunk_hs) - OUT_W'(res_take);
    acc_n         = res_take ? (acc + ACC_W'(bus.dp_res)) : acc;

    case (state)
      IDLE: begin
        if (job_hs) begin
          len_n         = (bus.job_len > MAX_LEN) ? MAX_LEN : bus.job_len;
          issued_n      = '0;
          returned_n    = '0;
          outstanding_n = '0;
          acc_n         = '0;
          state_n       = (bus.job_len != '0) ? ISSUE : DONE;
        end
      end
      ISSUE:   if (issued_n == len) state_n = DRAIN;
      DRAIN:   if (returned_n == len) state_n = DONE;
      DONE:    if (res_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      len              <= '0;
      issued           <= '0;
      returned         <= '0;
      outstanding      <= '0;
      acc              <= '0;
      bus.job_ready    <= 1'b0;
      bus.chunk_ready  <= 1'b0;
      bus.dp_start     <= 1'b0;
      bus.dp_vec_a     <= '0;
      bus.dp_vec_b     <= '0;
      bus.res_valid    <= 1'b0;
      bus.res_data     <= '0;
      bus.res_chunks   <= '0;
      bus.busy         <= 1'b0;
      bus.err_spurious <= 1'b0;
    end else begin
      state       <= state_n;
      len         <= len_n;
      issued      <= issued_n;
      returned    <= returned_n;
      outstanding <= outstanding_n;
      acc         <= acc_n;

      bus.job_ready   <= (state_n == IDLE);
      // Credit uses only the registered count, so a return frees a slot one cycle later.
      bus.chunk_ready <= (state_n == ISSUE) && (issued_n < len_n) && (outstanding_n < MAX_OUT);
      bus.dp_start    <= chunk_hs;
      if (chunk_hs) begin
        bus.dp_vec_a <= bus.chunk_a;
        bus.dp_vec_b <= bus.chunk_b;
      end

      bus.res_valid <= (state_n == DONE);
      if (state_n == DONE) begin
        bus.res_data   <= acc_n;
        bus.res_chunks <= len_n;
      end

      bus.busy         <= (state_n != IDLE);
      bus.err_spurious <= bus.err_spurious | res_drop;
    end
  end
endmodule

// File: tb/tb_dot_product_seq_ctrl.sv
// Self-checking bench: directed vector table, hand-written reset/spurious
// sequences and random jobs checked against a counting reference model.
`timescale 1ns/1ps
module tb_dot_product_seq_ctrl;
  localparam int unsigned ACC_W = 23;
  localparam int MAXC = 16;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dot_product_seq_ctrl_if #(.ACC_W(ACC_W), .LEN_W(5)) bus ();

  dot_product_seq_ctrl #(
    .MAX_CHUNKS(16), .MAX_OUTSTANDING(4), .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [18:0] dot8(input logic [63:0] a, input logic [63:0] b);
    int s = 0;
    for (int i = 0; i < 8; i++) s += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
    return 19'(s);
  endfunction

  // Behavioural datapath: every dp_start returns its dot product exactly lat cycles later.
  typedef struct { int due; logic [18:0] val; } dp_item_t;
  dp_item_t dpq[$];
  int lat = 2;
  int inj_req = 0;
  int inj_done = 0;
  int dp_starts = 0;

  always @(negedge clk) begin
    bus.dp_res_valid = 1'b0;
    bus.dp_res       = '0;
    if (rst === 1'b1) begin
      dpq.delete();
    end else begin
      if (bus.dp_start === 1'b1) begin
        dp_starts++;
        dpq.push_back('{due: cyc + lat, val: dot8(bus.dp_vec_a, bus.dp_vec_b)});
      end
      if (inj_req != inj_done) begin
        inj_done         = inj_req;
        bus.dp_res_valid = 1'b1;
        bus.dp_res       = 19'd5;
      end else if (dpq.size() > 0 && dpq[0].due <= cyc) begin
        bus.dp_res_valid = 1'b1;
        bus.dp_res       = dpq[0].val;
        void'(dpq.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [63:0] ca [MAXC];
  logic [63:0] cb [MAXC];
  bit exp_err = 1'b0;

  task automatic do_reset(input int ncyc);
    bus.job_valid   = 1'b0;
    bus.chunk_valid = 1'b0;
    bus.res_ready   = 1'b0;
    rst = 1'b1;
    repeat (ncyc) step();
    rst = 1'b0;
    step();
    exp_err = 1'b0;
  endtask

  task automatic wait_job_ready(input string tag);
    int k = 0;
    while (bus.job_ready !== 1'b1 && k < 50) begin step(); k++; end
    chk({tag, "_job_ready_wait"}, 64'(bus.job_ready), 1);
  endtask

  // Runs one job; the model tracks issued/returned counts to predict
  // chunk_ready every cycle and the result timing.
  task automatic run_job(input string tag, input int len, input int l, input int vpct,
                         input int rr_hold, input longint exp_sum, input bit chk_lat);
    int n, t0, hs, ret, last_ret, first_hs, first_dp, rv_cyc, prof_bad, hold_bad;
    bit done, exp_cr;
    n = (len > MAXC) ? MAXC : len;
    lat = l;
    dp_starts = 0;
    wait_job_ready(tag);
    bus.job_valid = 1'b1;
    bus.job_len   = 5'(len);
    t0 = cyc;
    hs = 0; ret = 0; last_ret = t0; first_hs = -1; first_dp = -1; rv_cyc = -1;
    prof_bad = 0; done = 1'b0;
    step();
    bus.job_valid = 1'b0;
    for (int k = 0; k < 600 && !done; k++) begin
      if (bus.dp_start === 1'b1 && first_dp < 0) first_dp = cyc;
      if (bus.res_valid === 1'b1) begin
        rv_cyc = cyc;
        done = 1'b1;
      end else begin
        exp_cr = (hs < n) && (hs - ret < MAXO);
        if (bus.chunk_ready !== exp_cr) prof_bad++;
        if (bus.busy !== 1'b1 || bus.job_ready !== 1'b0) prof_bad++;
        if (hs < n && $urandom_range(99) < vpct) begin
          bus.chunk_valid = 1'b1;
          bus.chunk_a     = ca[hs];
          bus.chunk_b     = cb[hs];
          if (bus.chunk_ready === 1'b1) begin
            if (first_hs < 0) first_hs = cyc;
            hs++;
          end
        end else begin
          bus.chunk_valid = 1'b0;
        end
        if (bus.dp_res_valid === 1'b1) begin
          ret++;
          last_ret = cyc;
        end
        step();
      end
    end
    bus.chunk_valid = 1'b0;
    chk({tag, "_res_valid_seen"}, 64'(done), 1);
    if (!done) begin
      do_reset(2);
      return;
    end
    chk({tag, "_res_data"}, 64'(bus.res_data), 64'(exp_sum));
    chk({tag, "_res_chunks"}, 64'(bus.res_chunks), 64'(n));
    chk({tag, "_dp_start_count"}, 64'(dp_starts), 64'(n));
    chk({tag, "_res_valid_cycle"}, 64'(rv_cyc), 64'((n == 0) ? t0 + 1 : last_ret + 1));
    chk({tag, "_chunk_ready_profile_errors"}, 64'(prof_bad), 0);
    chk({tag, "_err_spurious"}, 64'(bus.err_spurious), 64'(exp_err));
    if (chk_lat) begin
      chk({tag, "_chunk_accept_cycle"}, 64'(first_hs), 64'(t0 + 1));
      chk({tag, "_dp_start_cycle"}, 64'(first_dp), 64'(t0 + 2));
      chk({tag, "_dp_res_cycle"}, 64'(last_ret), 64'(t0 + 2 + l));
    end
    hold_bad = 0;
    for (int i = 0; i < rr_hold; i++) begin
      bus.res_ready = 1'b0;
      step();
      if (bus.res_valid !== 1'b1 || bus.res_data !== ACC_W'(exp_sum) ||
          bus.job_ready !== 1'b0 || bus.res_chunks !== 5'(n)) hold_bad++;
    end
    chk({tag, "_hold_stable_errors"}, 64'(hold_bad), 0);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk({tag, "_idle_after_ready"}, {61'd0, bus.job_ready, bus.res_valid, bus.busy}, 64'b100);
  endtask

  typedef struct {
    int          len;
    int          lat;
    int          rr_hold;
    logic [7:0]  ea;
    logic [7:0]  eb;
    longint      exp;
    bit          chk_lat;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint model;
    int     len, hs, k;
    rst = 1'b1;
    bus.job_valid = 1'b0; bus.job_len = '0; bus.chunk_valid = 1'b0;
    bus.chunk_a = '0; bus.chunk_b = '0; bus.res_ready = 1'b0;
    repeat (3) step();
    chk("rst_chunk_ready", 64'(bus.chunk_ready), 0);
    chk("rst_dp_start", 64'(bus.dp_start), 0);
    chk("rst_res_valid", 64'(bus.res_valid), 0);
    chk("rst_res_data", 64'(bus.res_data), 0);
    chk("rst_res_chunks", 64'(bus.res_chunks), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_err_spurious", 64'(bus.err_spurious), 0);
    rst = 1'b0;
    step();
    chk("post_rst_job_ready", 64'(bus.job_ready), 1);

    // len, lat, rr_hold, elem a, elem b, expected sum, check latency
    tbl[0] = '{1,  3, 0, 8'h01, 8'h01, 8,       1'b1};
    tbl[1] = '{16, 6, 0, 8'hFF, 8'hFF, 8323200, 1'b0};
    tbl[2] = '{0,  2, 0, 8'h00, 8'h00, 0,       1'b0};
    tbl[3] = '{3,  2, 5, 8'h02, 8'h03, 144,     1'b0};
    tbl[4] = '{8,  2, 0, 8'h01, 8'h07, 448,     1'b0};
    tbl[5] = '{25, 1, 2, 8'h10, 8'h10, 32768,   1'b0};
    tbl[6] = '{1,  1, 1, 8'hFF, 8'hFF, 520200,  1'b1};
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < MAXC; i++) begin
        ca[i] = {8{tbl[v].ea}};
        cb[i] = {8{tbl[v].eb}};
      end
      run_job($sformatf("vec%0d", v), tbl[v].len, tbl[v].lat, 100, tbl[v].rr_hold,
              tbl[v].exp, tbl[v].chk_lat);
    end

    // Reset after two of four chunks issued; late result must be flagged.
    for (int i = 0; i < MAXC; i++) begin ca[i] = {8{8'h01}}; cb[i] = {8{8'h01}}; end
    lat = 4;
    wait_job_ready("midrst");
    bus.job_valid = 1'b1; bus.job_len = 5'd4;
    step();
    bus.job_valid = 1'b0;
    hs = 0; k = 0;
    while (hs < 2 && k < 50) begin
      bus.chunk_valid = 1'b1; bus.chunk_a = ca[hs]; bus.chunk_b = cb[hs];
      if (bus.chunk_ready === 1'b1) hs++;
      step(); k++;
    end
    chk("midrst_issued", 64'(hs), 2);
    bus.chunk_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("midrst_busy", 64'(bus.busy), 0);
    chk("midrst_res_valid", 64'(bus.res_valid), 0);
    chk("midrst_chunk_ready", 64'(bus.chunk_ready), 0);
    chk("midrst_err_clear", 64'(bus.err_spurious), 0);
    rst = 1'b0;
    inj_req++;
    step();
    step();
    chk("late_result_err", 64'(bus.err_spurious), 1);
    exp_err = 1'b1;
    run_job("after_midrst", 2, 3, 100, 0, 16, 1'b0);
    do_reset(2);
    chk("err_cleared_by_rst", 64'(bus.err_spurious), 0);

    // Spurious result while holding a result in DONE must not disturb it.
    wait_job_ready("done_spur");
    bus.job_valid = 1'b1; bus.job_len = 5'd0;
    step();
    bus.job_valid = 1'b0;
    inj_req++;
    step();
    step();
    chk("done_spur_res_valid", 64'(bus.res_valid), 1);
    chk("done_spur_res_data", 64'(bus.res_data), 0);
    chk("done_spur_err", 64'(bus.err_spurious), 1);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    do_reset(2);

    // Random jobs against the summed-products model.
    for (int j = 0; j < 20; j++) begin
      len = $urandom_range(0, 18);
      for (int i = 0; i < MAXC; i++) begin
        ca[i] = {$urandom, $urandom};
        cb[i] = {$urandom, $urandom};
      end
      model = 0;
      for (int i = 0; i < ((len > MAXC) ? MAXC : len); i++) model += longint'(dot8(ca[i], cb[i]));
      run_job($sformatf("rnd%0d", j), len, $urandom_range(1, 8), $urandom_range(30, 100),
              $urandom_range(0, 3), model, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dot_product_seq_ctrl.md
DOT_PRODUCT_SEQ_CTRL -- requirements
Module: dot_product_seq_ctrl

Interface
REQ-001 Parameter MAX_CHUNKS, 16: max 8-element chunks per job.
REQ-002 Parameter MAX_OUTSTANDING, 4: max datapath operations in flight.
REQ-003 Parameter ACC_W, 23: accumulator/result width (19 + clog2(MAX_CHUNKS)).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 job_valid  in  1  job request; job_ready  out  1  job accept; job_len  in  5  chunk count, 0..MAX_CHUNKS.
REQ-007 chunk_valid  in  1; chunk_ready  out  1; chunk_a, chunk_b  in  64 each  eight unsigned 8-bit elements, element i = bits [8i+7:8i].
REQ-008 dp_start  out  1  one-cycle issue pulse to the tree-add datapath; dp_vec_a, dp_vec_b  out  64 each  operands valid with dp_start.
REQ-009 dp_res_valid  in  1  one pulse per issued op, in issue order; dp_res  in  19  chunk dot product.
REQ-010 res_valid  out  1; res_ready  in  1; res_data  out  ACC_W  job sum; res_chunks  out  5  chunks accumulated.
REQ-011 busy  out  1  high whenever state != IDLE; err_spurious  out  1  sticky protocol-error flag.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, DRAIN, DONE.
REQ-013 IDLE: job_ready=1; on job_valid SHALL latch job_len, clear acc, issued, returned and outstanding counters; go to ISSUE if job_len>0, else DONE.
REQ-014 job_ready SHALL be 0 in every state other than IDLE.
REQ-015 ISSUE: chunk_ready=1 iff issued<len and outstanding<MAX_OUTSTANDING; chunk_ready SHALL be 0 in all other states.
REQ-016 Chunk handshake (chunk_valid & chunk_ready) at cycle t SHALL produce dp_start=1 at t+1, with dp_vec_a/b registered from chunk_a/b; dp_start=0 otherwise.
REQ-017 When issued reaches len, the FSM SHALL go ISSUE->DRAIN on the same edge as the last handshake.
REQ-018 In ISSUE or DRAIN, dp_res_valid with outstanding>0 SHALL add zero-extended dp_res to acc and increment returned.
REQ-019 Outstanding SHALL increment on handshake and decrement on accepted result; both in one cycle leave it unchanged.
REQ-020 Credit check SHALL use the registered outstanding count (no same-cycle credit return).
REQ-021 DRAIN->DONE SHALL occur on the edge where returned reaches len; res_valid rises the following cycle.
REQ-022 DONE: res_valid=1, res_data=acc, res_chunks=len held stable until res_ready; on res_valid & res_ready go to IDLE.
REQ-023 job_len=0 SHALL yield res_data=0, res_chunks=0, with no chunk handshake and no dp_start.
REQ-024 job_len>MAX_CHUNKS SHALL be clamped to MAX_CHUNKS.
REQ-025 dp_res_valid with outstanding=0, or in IDLE/DONE, SHALL be dropped (acc unchanged) and set err_spurious.
REQ-026 Accumulator SHALL NOT overflow: 16 x 524287 < 2^23; no saturation logic.
REQ-027 Minimum latency, len=1, datapath latency L: job accept t0, chunk accept t0+1, dp_start t0+2, dp_res_valid t0+2+L, res_valid t0+3+L.

Reset
REQ-028 rst=1 at any edge, including mid-job, SHALL force IDLE and clear acc, all counters, dp_vec_a/b and err_spurious.
REQ-029 Reset values: job_ready=1 (after first edge out of reset), chunk_ready=0, dp_start=0, res_valid=0, res_data=0, res_chunks=0, busy=0, err_spurious=0.
REQ-030 Results in flight at reset SHALL be dropped and flag err_spurious; the bench resets datapath and controller together.

Verification
REQ-031 len=1, chunk_a=chunk_b=0x0101010101010101, datapath returns 8 -> res_data=8, res_chunks=1, cycle timing per REQ-027.
REQ-032 len=16, all bytes 0xFF, chunk_valid always high, L=6 -> chunk_ready drops after 4 issues until the first return; res_data=8323200.
REQ-033 len=0 -> res_valid next cycle after accept, res_data=0, dp_start never asserted.
REQ-034 len=3, res_ready held low 5 cycles in DONE -> res_valid/res_data stable, job_ready=0 throughout; IDLE one cycle after res_ready=1.
REQ-035 rst pulsed after 2 of 4 chunks issued -> next cycle busy=0, res_valid=0, acc=0; late dp_res_valid sets err_spurious.
REQ-036 Chunk-handshake and dp_res_valid in the same cycle with outstanding=MAX_OUTSTANDING-1 -> outstanding unchanged; accumulation correct.
